mem_access_unit: RTL

Load/store initiator sitting between the Beta core's execute stage and the byte-addressed, little-endian data memory. Accepts one LD/ST request at a time over a valid/ready handshake and checks word alignment and address range. Drives the memory's address, write-data and write-enable lines for a fixed, parameterised access window. Returns read data, or a store acknowledge, as a one-cycle response pulse.

---
 rtl/beta_mem_pkg.sv | 7 +
 rtl/mem_access_unit.sv | 80 ++++++++
 2 files changed

// File: rtl/beta_mem_pkg.sv
// beta_mem_pkg: shared types and constants for the Beta data-memory path
package beta_mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_e;
    localparam int WORD_BYTES = 4;
    localparam logic [1:0] ALIGN_MASK = 2'b11;
    localparam logic [31:0] DEFAULT_ADDR_LIMIT = 32'h0100_0000;
endpackage

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding LD/ST initiator with alignment/range fault checks
module mem_access_unit
    import beta_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = DEFAULT_ADDR_LIMIT,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wd,
    output logic        mem_wr,
    input  logic [31:0] mem_rd
);
    localparam logic [31:0] LAST_WORD = ADDR_LIMIT - 32'(WORD_BYTES);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    state_e state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic bad;
    assign bad = (req_addr[1:0] & ALIGN_MASK) != 2'b00 || req_addr > LAST_WORD;
    // addr/wdata only latch for accepted good requests so the memory lines hold through faults
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d    = req_we;
                state_d = bad ? FAULT : ACCESS;
                rdata_d = bad ? '0 : rdata_q;
                addr_d  = bad ? addr_q : req_addr;
                wdata_d = bad ? wdata_q : req_wdata;
                wait_d  = bad ? wait_q : WAIT_INIT;
            end
            ACCESS: begin
                state_d = wait_q == 4'd0 ? RESP : ACCESS;
                wait_d  = wait_q == 4'd0 ? 4'd0 : wait_q - 4'd1;
                rdata_d = wait_q != 4'd0 ? rdata_q : (we_q ? '0 : mem_rd);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
    assign req_ready   = state_q == IDLE;
    assign rsp_valid   = state_q == RESP || state_q == FAULT;
    assign rsp_fault   = state_q == FAULT;
    assign rsp_rdata   = rdata_q;
    assign mem_address = addr_q;
    assign mem_wd      = wdata_q;
    assign mem_wr      = state_q == ACCESS && we_q && wait_q == WAIT_INIT;
endmodule
